wb_debug_master: RTL and testbench
==================================

# wb_debug_master

Byte-stream-to-Wishbone debug bridge: a second bus initiator alongside the CPU's instruction-fetch and load/store masters. It parses host read/write commands arriving as bytes from a UART receiver and issues single 32-bit Wishbone classic cycles. It returns acknowledgements or read data as bytes to a UART transmitter. Used for loading RAM/ROM images and peeking/poking memory-mapped registers without CPU involvement.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: max cycles `stb` is held waiting for `ack` before the bridge abandons the cycle.

Ports:
- clk  input  1  system clock; the single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- wishbone  wishbone_if.master  -  bus master port, using signals cyc, stb, we, sel[3:0], adr[31:0], dat_w[31:0], dat_r[31:0], ack.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe, `rx_data` valid; no backpressure.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  `tx_data` valid.
- tx_ready  input  1  transmitter accepts the byte when `tx_valid` and `tx_ready` are both high.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  one-cycle pulse when an rx byte is dropped.

## Operation
- Frame formats; all multi-byte fields are little-endian:
  - Write: 0x57, then addr[4], then data[4]. Response: 0x06 (ACK).
  - Read: 0x52, then addr[4]. Response: data[4].
  - Any other first byte: respond 0x15 (NAK) and return to IDLE.
- States:
  - IDLE: on `rx_valid`, latch the command and go to ADDR. An unknown command goes to RESP with NAK instead.
  - ADDR: shift in 4 bytes (byte count 0..3). After the 4th, a write goes to DATA and a read goes to BUS.
  - DATA: shift in 4 bytes, then go to BUS.
  - BUS: drive cyc=stb=1, we=(cmd==W), sel=4'hF, adr=latched address unmodified, dat_w=latched data.
    - On `ack`: latch `dat_r` for reads, then go to RESP.
    - On timeout: go to RESP with NAK.
  - RESP: emit 1 byte (write, or NAK) or 4 bytes (read data, LSB first), then go to IDLE.
- Only one transaction is ever outstanding. No pipelining, no burst, no retry.
- `rx_valid` while in BUS or RESP: drop the byte, pulse `overrun`, and leave the state unchanged.
- No inter-byte timeout. A partial frame waits indefinitely; only `reset` clears it.

## Timing
- Reset values: cyc=stb=we=0, sel=0, adr=0, dat_w=0, tx_valid=0, tx_data=0, busy=0, overrun=0. All counters are 0 and the state is IDLE.
- Reset asserted mid-cycle drops cyc/stb asynchronously in the same cycle. Nothing is emitted afterwards.
- Last frame byte strobed in cycle N: cyc/stb are high from cycle N+1 (all outputs are registered).
- `ack` is sampled on the rising edge while `stb` is high; a same-cycle ack is legal.
  - With `ack` seen at edge K: cyc/stb are low and tx_valid=1 after edge K.
  - Zero-wait-state slave: stb is high for exactly 1 cycle.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It is cleared on entry to BUS and increments each BUS cycle without `ack`.
  - After TIMEOUT_CYCLES cycles with stb high and no ack, cyc/stb drop on the next edge and the NAK is queued.
  - `ack` arriving in the same cycle the count expires wins: normal completion.
- `tx_data` holds stable while tx_valid && !tx_ready.
  - Each handshake advances to the next byte in the following cycle.
  - Back-to-back bytes are allowed (tx_valid stays high).
- `busy` is registered and follows the state.

## Structure
- Package `wb_debug_pkg`:
  - Command constants CMD_WRITE=8'h57, CMD_READ=8'h52.
  - Response constants RSP_ACK=8'h06, RSP_NAK=8'h15.
  - State enum {IDLE, ADDR, DATA, BUS, RESP}.
- No sub-module: the byte assembler and serializer are 32-bit shift registers inline with a shared 2-bit byte counter.
- The module connects to the switch as an additional master, arbitrated alongside the CPU masters.

## Test plan
- Write: 57 00 00 00 10 EF BE AD DE, with a RAM slave acking after 2 wait states -> one cycle with adr=0x1000_0000, dat_w=0xDEADBEEF, we=1, sel=F, stb high 3 cycles; tx emits 06.
- Read: 52 00 00 00 10 with slave returning 0xCAFEF00D on a same-cycle ack -> stb high exactly 1 cycle, we=0; tx emits 0D F0 FE CA. Hold tx_ready low 5 cycles mid-stream -> bytes are not lost or duplicated.
- Unknown command 0x41 -> tx emits 15, no bus activity, busy low afterwards.
- Slave never acks, TIMEOUT_CYCLES=16 -> stb high exactly 16 cycles then low; tx emits 15; the next valid read completes normally.
- Extra rx byte during BUS -> overrun pulses once, transaction result is unchanged.
- Reset asserted while stb is high -> cyc/stb low immediately, no tx byte; a subsequent write frame completes.

Source files
------------

// File: rtl/wb_debug_pkg.sv
// wb_debug_pkg: command/response codes and state encoding for the debug bridge
package wb_debug_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: single 32-bit Wishbone classic bus bundle
interface wishbone_if;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  modport master(output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave(input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_debug_master.sv
// wb_debug_master: byte-stream command parser issuing single Wishbone classic cycles
module wb_debug_master
  import wb_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  wishbone_if.master wishbone,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t          state;
  logic            wr, one;
  logic [1:0]      cnt;
  logic [23:0]     shift;
  logic [TW-1:0]   tmo;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wr             <= 1'b0;
      one            <= 1'b0;
      cnt            <= 2'd0;
      shift          <= 24'h0;
      tmo            <= '0;
      wishbone.cyc   <= 1'b0;
      wishbone.stb   <= 1'b0;
      wishbone.we    <= 1'b0;
      wishbone.sel   <= 4'h0;
      wishbone.adr   <= 32'h0;
      wishbone.dat_w <= 32'h0;
      tx_data        <= 8'h0;
      tx_valid       <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          wr   <= rx_data == CMD_WRITE;
          busy <= 1'b1;
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) state <= ADDR;
          else begin
            state    <= RESP;
            one      <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= RSP_NAK;
          end
        end
        // little-endian fields: each new byte enters at the top and slides down
        ADDR: if (rx_valid) begin
          wishbone.adr <= {rx_data, wishbone.adr[31:8]};
          cnt          <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state        <= wr ? DATA : BUS;
            wishbone.cyc <= !wr;
            wishbone.stb <= !wr;
            wishbone.we  <= 1'b0;
            wishbone.sel <= wr ? 4'h0 : 4'hF;
            tmo          <= '0;
          end
        end
        DATA: if (rx_valid) begin
          wishbone.dat_w <= {rx_data, wishbone.dat_w[31:8]};
          cnt            <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state        <= BUS;
            wishbone.cyc <= 1'b1;
            wishbone.stb <= 1'b1;
            wishbone.we  <= 1'b1;
            wishbone.sel <= 4'hF;
            tmo          <= '0;
          end
        end
        // ack is checked before the timeout so a late ack on the last cycle still completes
        BUS: begin
          overrun <= rx_valid;
          if (wishbone.ack || tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state        <= RESP;
            wishbone.cyc <= 1'b0;
            wishbone.stb <= 1'b0;
            wishbone.we  <= 1'b0;
            wishbone.sel <= 4'h0;
            tx_valid     <= 1'b1;
            one          <= !wishbone.ack || wr;
            tx_data      <= !wishbone.ack ? RSP_NAK : wr ? RSP_ACK : wishbone.dat_r[7:0];
            shift        <= wishbone.dat_r[31:8];
          end else tmo <= tmo + 1'b1;
        end
        RESP: begin
          overrun <= rx_valid;
          if (tx_ready) begin
            if (one || cnt == 2'd3) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              cnt      <= 2'd0;
            end else begin
              cnt     <= cnt + 2'd1;
              tx_data <= shift[7:0];
              shift   <= {8'h00, shift[23:8]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_debug_master.sv
// tb_wb_debug_master: randomized frames against a memory-level reference model
module tb_wb_debug_master;
  localparam int TO = 16;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy, overrun;
  wishbone_if wb();
  wb_debug_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wishbone(wb), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave: responds after `waits` wait states unless `hang`
  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem [16];
  int waits = 0, wcnt = 0;
  bit hang = 0;
  assign wb.ack   = wb.cyc && wb.stb && !hang && (wcnt == waits);
  assign wb.dat_r = slave_mem[wb.adr[5:2]];
  always @(posedge clk) begin
    wcnt <= (wb.cyc && wb.stb && !wb.ack) ? wcnt + 1 : 0;
    if (wb.cyc && wb.stb && wb.ack && wb.we) slave_mem[wb.adr[5:2]] <= wb.dat_w;
  end

  // monitors
  logic [7:0]  tx_q[$];
  int          stb_cycles = 0, n_acks = 0, ov_cnt = 0;
  logic [31:0] mon_adr, mon_dat;
  logic        mon_we;
  logic [3:0]  mon_sel;
  logic        prev_v = 0, prev_r = 0;
  logic [7:0]  prev_d = 0;
  always @(negedge clk) begin
    if (prev_v && !prev_r && !reset) check("tx_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, prev_d});
    if (wb.cyc && wb.stb) begin
      stb_cycles++;
      if (wb.ack) begin
        n_acks++;
        mon_adr = wb.adr; mon_dat = wb.dat_w; mon_we = wb.we; mon_sel = wb.sel;
      end
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (overrun) ov_cnt++;
    prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
  end

  // transmitter: optional random backpressure plus one directed stall
  bit rnd_ready = 0;
  int stall = 0, stall_at = -1;
  always @(posedge clk) begin
    #1;
    if (stall_at >= 0 && tx_q.size() == stall_at) begin stall = 5; stall_at = -1; end
    if (stall > 0) begin tx_ready = 1'b0; stall--; end
    else tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                           input int w, input bit inject);
    logic [7:0]  exp[$];
    logic [31:0] word;
    int          idx = int'(adr[5:2]);
    bit          known = (cmd == 8'h57 || cmd == 8'h52);
    bit          wr = (cmd == 8'h57);
    int          i;
    waits = w; tx_q.delete(); stb_cycles = 0; n_acks = 0; ov_cnt = 0;
    if (!known || hang) exp.push_back(8'h15);
    else if (wr) begin exp.push_back(8'h06); ref_mem[idx] = dat; end
    else begin
      word = ref_mem[idx];
      for (int k = 0; k < 4; k++) exp.push_back(word[8*k +: 8]);
    end
    send(cmd);
    if (known) for (int k = 0; k < 4; k++) send(adr[8*k +: 8]);
    if (wr) for (int k = 0; k < 4; k++) send(dat[8*k +: 8]);
    if (inject) send(8'hAA);
    for (i = 0; i < 3000 && !(tx_q.size() >= exp.size() && !busy); i++) @(negedge clk);
    check("done", {31'h0, i < 3000}, 32'h1);
    repeat (3) @(negedge clk);
    check("tx_count", tx_q.size(), exp.size());
    for (int k = 0; k < exp.size() && k < tx_q.size(); k++) check("tx_byte", {24'h0, tx_q[k]}, {24'h0, exp[k]});
    check("stb_cycles", stb_cycles, !known ? 0 : hang ? TO : w + 1);
    check("acks", n_acks, (known && !hang) ? 1 : 0);
    if (known && !hang && n_acks == 1) begin
      check("adr", mon_adr, adr);
      check("we_sel", {27'h0, mon_we, mon_sel}, {27'h0, wr, 4'hF});
      if (wr) check("dat_w", mon_dat, dat);
    end
    check("overrun", ov_cnt, inject ? 1 : 0);
    check("busy_idle", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    logic [31:0] a;
    for (int k = 0; k < 16; k++) begin
      slave_mem[k] = (32'h0101_0101 * k) ^ 32'h5A5A_0000;
      ref_mem[k]   = (32'h0101_0101 * k) ^ 32'h5A5A_0000;
    end
    slave_mem[0] = 32'hCAFE_F00D;
    ref_mem[0]   = 32'hCAFE_F00D;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_cyc_stb_we", {29'h0, wb.cyc, wb.stb, wb.we}, 32'h0);
    check("rst_sel", {28'h0, wb.sel}, 32'h0);
    check("rst_adr", wb.adr, 32'h0);
    check("rst_dat_w", wb.dat_w, 32'h0);
    check("rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    check("rst_busy_ovr", {30'h0, busy, overrun}, 32'h0);
    reset = 1'b0;

    stall_at = 2;
    run_frame(8'h52, 32'h1000_0000, 32'h0, 0, 0);
    run_frame(8'h57, 32'h1000_0000, 32'hDEAD_BEEF, 2, 0);
    run_frame(8'h41, 32'h0, 32'h0, 0, 0);
    hang = 1;
    run_frame(8'h52, 32'h1000_0004, 32'h0, 0, 0);
    hang = 0;
    run_frame(8'h52, 32'h1000_0004, 32'h0, 1, 0);
    run_frame(8'h57, 32'h1000_000C, 32'h1234_5678, 3, 1);

    // reset while a cycle is stalled on the bus
    hang = 1; tx_q.delete();
    send(8'h57);
    for (int k = 0; k < 8; k++) send(8'h11 * k[7:0]);
    repeat (3) @(posedge clk);
    check("stb_before_rst", {31'h0, wb.stb}, 32'h1);
    #2 reset = 1'b1;
    #1 check("rst_async_cyc_stb", {30'h0, wb.cyc, wb.stb}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; hang = 0;
    repeat (5) @(negedge clk);
    check("rst_no_tx", tx_q.size(), 0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    run_frame(8'h57, 32'h1000_0008, 32'h0BAD_F00D, 1, 0);
    run_frame(8'h52, 32'h1000_0008, 32'h0, 0, 0);

    rnd_ready = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          c = 8'($urandom);
          while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
        end
        1, 2, 3, 4: c = 8'h57;
        default: c = 8'h52;
      endcase
      a = $urandom;
      run_frame(c, a, $urandom, $urandom_range(0, 3), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
